// File: rtl/sound_scheduler.sv
// sound_scheduler: shares one tone generator among lose/win/gate/hop events as timed melodies
// Optional feature macro: SOUND_PREEMPT_EN lets a higher-priority event cut a melody short.
module sound_scheduler #(
    parameter int NOTE_TICKS = 25000000,
    parameter int GAP_TICKS  = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lose_req,
    input  logic       win_req,
    input  logic       gate_req,
    input  logic       hop_req,
    output logic [9:0] sound_freq_out,
    output logic       enable_sound,
    output logic       busy,
    output logic [3:0] grant
);
    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
    localparam logic [25:0] NOTE_LOAD = 26'(NOTE_TICKS - 1);
    localparam logic [25:0] GAP_LOAD  = 26'(GAP_TICKS - 1);
    state_t      state, state_nxt;
    logic [3:0]  pending, pend_all, pick, src;
    logic [1:0]  note_idx, last_idx;
    logic [25:0] cnt;
    logic        take;
    logic [9:0]  rom_freq;
    assign pend_all = pending | {hop_req, gate_req, win_req, lose_req};
    // lowest set bit is the highest-priority request (bit 0 = lose)
    assign pick     = pend_all & (~pend_all + 4'd1);
    assign last_idx = (src[0] | src[1]) ? 2'd2 : src[2] ? 2'd1 : 2'd0;
`ifdef SOUND_PREEMPT_EN
    assign take = (state == IDLE) ? (pend_all != 4'd0) : (pick != 4'd0 && pick < src);
`else
    assign take = (state == IDLE) && (pend_all != 4'd0);
`endif
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    // next-state decision: a grant always restarts at the first note
    always_comb begin
        state_nxt = take ? TONE :
                    (state == TONE) ? ((cnt == 26'd0) ? GAP : TONE) :
                    (state == GAP)  ? ((cnt == 26'd0) ? ((note_idx == last_idx) ? IDLE : TONE) : GAP) :
                    IDLE;
    end
    // pending latch, granted source, note index and tick counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 4'd0;
            src      <= 4'd0;
            note_idx <= 2'd0;
            cnt      <= 26'd0;
        end else begin
            pending <= take ? (pend_all & ~pick) : pend_all;
            if (take) begin
                src      <= pick;
                note_idx <= 2'd0;
                cnt      <= NOTE_LOAD;
            end else if (state != IDLE) begin
                if (cnt != 26'd0)
                    cnt <= cnt - 26'd1;
                else if (state == TONE)
                    cnt <= GAP_LOAD;
                else if (note_idx != last_idx) begin
                    note_idx <= note_idx + 2'd1;
                    cnt      <= NOTE_LOAD;
                end
            end
        end
    end
    // melody ROM lookup and output decode from registered state
    always_comb begin
        rom_freq = 10'd0;
        case (src)
            4'b0001: rom_freq = (note_idx == 2'd0) ? 10'd950 : (note_idx == 2'd1) ? 10'd800 : 10'd650;
            4'b0010: rom_freq = (note_idx == 2'd0) ? 10'd500 : (note_idx == 2'd1) ? 10'd400 : 10'd300;
            4'b0100: rom_freq = (note_idx == 2'd0) ? 10'd700 : 10'd600;
            4'b1000: rom_freq = 10'd300;
            default: rom_freq = 10'd0;
        endcase
        enable_sound   = (state == TONE);
        sound_freq_out = (state == TONE) ? rom_freq : 10'd0;
        busy           = (state != IDLE);
        grant          = (state != IDLE) ? src : 4'd0;
    end
endmodule
